// File: rtl/dmem_access_unit_pkg.sv
// dmem_pkg: shared types and constants for the memory-stage access unit.
// The optional store-to-load forwarding path is enabled with the macro
// DMEM_STORE_FORWARD_EN (consumed by store_buffer and dmem_access_unit).
package dmem_pkg;

    localparam int DMEM_SB_DEPTH_DEFAULT = 4;

    // Widths of the buffered address/data fields; the top may use AW/DW up to these.
    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    // Clears the byte offset so every RAM access is word aligned.
    localparam logic [DMEM_AW-1:0] DMEM_WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } dmem_state_t;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] data;
    } sb_entry_t;

    function automatic logic [DMEM_AW-1:0] wordAlign(input logic [DMEM_AW-1:0] byteAddr);
        return byteAddr & DMEM_WORD_MASK;
    endfunction

endpackage

// File: rtl/dmem_access_unit_store_buffer.sv
// store_buffer: in-order circular FIFO of pending stores.
// With DMEM_STORE_FORWARD_EN defined it also exposes a search port that
// returns the youngest buffered entry whose word address matches.
module store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_SB_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq,
    input  sb_entry_t          enqEntry,
    input  logic               deq,
    output logic               full,
    output logic               empty,
    output sb_entry_t          head
`ifdef DMEM_STORE_FORWARD_EN
    ,
    input  logic [DMEM_AW-1:0] matchAddr,
    output logic               matchHit,
    output logic [DMEM_DW-1:0] matchData
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] rdPtrReg;
    logic [PW-1:0] wrPtrReg;
    logic [PW:0]   countReg;
    logic          doEnq;
    logic          doDeq;

    assign full  = (countReg == FULL_COUNT);
    assign empty = (countReg == '0);
    assign doEnq = enq & ~full;
    assign doDeq = deq & ~empty;
    assign head  = entries[rdPtrReg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doEnq) begin
                wrPtrReg <= wrPtrReg + PW'(1);
            end
            if (doDeq) begin
                rdPtrReg <= rdPtrReg + PW'(1);
            end
            countReg <= countReg + {{PW{1'b0}}, doEnq} - {{PW{1'b0}}, doDeq};
        end
    end

    // Entry storage; slots outside the valid window are never read, so no reset
    always_ff @(posedge clk) begin
        if (doEnq) begin
            entries[wrPtrReg] <= enqEntry;
        end
    end

`ifdef DMEM_STORE_FORWARD_EN
    logic [DEPTH-1:0] slotMatch;

    // A slot matches when it lies inside the occupied window and holds the same word
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
            logic [PW-1:0] slotAge;
            assign slotAge       = PW'(gi) - rdPtrReg;
            assign slotMatch[gi] = ({1'b0, slotAge} < countReg) && (entries[gi].addr == matchAddr);
        end
    endgenerate

    // Walk from oldest to youngest so the last hit wins (youngest data)
    always_comb begin
        matchHit  = 1'b0;
        matchData = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (slotMatch[rdPtrReg + PW'(a)]) begin
                matchHit  = 1'b1;
                matchData = entries[rdPtrReg + PW'(a)].data;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage access unit in front of a single-port,
// variable-latency data RAM. Stores are posted into store_buffer and drained
// in order; loads wait for the buffer to empty and then read the RAM.
// Optional macro DMEM_STORE_FORWARD_EN: loads hitting a buffered word are
// answered from the buffer in one cycle without a RAM read.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = DMEM_SB_DEPTH_DEFAULT,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic          StallM,
    output logic [DW-1:0] ReadDataM,
    output logic          ReadValidM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    dmem_state_t   stateReg;
    logic          memReqReg;
    logic          memWeReg;
    logic [AW-1:0] memAddrReg;
    logic [DW-1:0] memWdataReg;
    logic [DW-1:0] readDataReg;
    logic          readValidReg;

    logic          isStore;
    logic          isLoad;
    logic [AW-1:0] alignedAddr;
    sb_entry_t     enqEntry;
    sb_entry_t     sbHead;
    logic          sbFull;
    logic          sbEmpty;
    logic          sbEnq;
    logic          sbDeq;

    // A store wins when both requests are raised together
    assign isStore     = MemWriteM;
    assign isLoad      = MemtoRegM & ~MemWriteM;
    assign alignedAddr = AW'(wordAlign(DMEM_AW'(ALUOutM)));

    // Enqueue is refused while full even if the head leaves this cycle
    assign sbEnq = isStore & ~sbFull;
    assign sbDeq = (stateReg == WR_REQ) & mem_gnt;

    // Pack the aligned store into a buffer entry
    always_comb begin
        enqEntry      = '0;
        enqEntry.addr = DMEM_AW'(alignedAddr);
        enqEntry.data = DMEM_DW'(WriteDataM);
    end

`ifdef DMEM_STORE_FORWARD_EN
    logic               fwdMatch;
    logic [DMEM_DW-1:0] fwdData;
    logic               fwdHit;

    // Forward only while no RAM read belongs to this load and it has not completed
    assign fwdHit = isLoad & fwdMatch & ~readValidReg &
                    ((stateReg == IDLE) | (stateReg == WR_REQ));
`endif

    store_buffer #(
        .DEPTH    (SB_DEPTH)
    ) uStoreBuffer (
        .clk      (clk),
        .reset    (reset),
        .enq      (sbEnq),
        .enqEntry (enqEntry),
        .deq      (sbDeq),
        .full     (sbFull),
        .empty    (sbEmpty),
        .head     (sbHead)
`ifdef DMEM_STORE_FORWARD_EN
        ,
        .matchAddr(DMEM_AW'(alignedAddr)),
        .matchHit (fwdMatch),
        .matchData(fwdData)
`endif
    );

    // The load retires in the cycle its registered result is presented
    assign StallM = (isStore & sbFull) | (isLoad & ~readValidReg);

    // Access FSM: drains stores ahead of loads, one RAM transaction at a time
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg     <= IDLE;
            memReqReg    <= 1'b0;
            memWeReg     <= 1'b0;
            memAddrReg   <= '0;
            memWdataReg  <= '0;
            readDataReg  <= '0;
            readValidReg <= 1'b0;
        end else begin
            readValidReg <= 1'b0;
`ifdef DMEM_STORE_FORWARD_EN
            if (fwdHit) begin
                readDataReg  <= DW'(fwdData);
                readValidReg <= 1'b1;
            end
`endif
            case (stateReg)
                IDLE: begin
                    if (!sbEmpty) begin
                        stateReg    <= WR_REQ;
                        memReqReg   <= 1'b1;
                        memWeReg    <= 1'b1;
                        memAddrReg  <= AW'(sbHead.addr);
                        memWdataReg <= DW'(sbHead.data);
                    end else if (isLoad && !readValidReg) begin
                        stateReg    <= RD_REQ;
                        memReqReg   <= 1'b1;
                        memWeReg    <= 1'b0;
                        memAddrReg  <= alignedAddr;
                    end
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        stateReg  <= IDLE;
                        memReqReg <= 1'b0;
                        memWeReg  <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        stateReg  <= RD_WAIT;
                        memReqReg <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        stateReg     <= RD_DONE;
                        readDataReg  <= mem_rdata;
                        readValidReg <= 1'b1;
                    end
                end
                RD_DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg  <= IDLE;
                    memReqReg <= 1'b0;
                    memWeReg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = memReqReg;
    assign mem_we     = memWeReg;
    assign mem_addr   = memAddrReg;
    assign mem_wdata  = memWdataReg;
    assign ReadDataM  = readDataReg;
    assign ReadValidM = readValidReg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized bench with a program-order memory model,
// a variable-latency RAM responder and directed corner cases.
module tb_dmem_access_unit;

    localparam int SB = 4;
`ifdef DMEM_STORE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemtoRegM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        StallM, ReadValidM;
    logic [31:0] ReadDataM;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_access_unit #(.SB_DEPTH(SB), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [31:0] ramMem [logic [31:0]];
    int          gntPct  = 100;
    int          rdDelay = 1;
    bit          rdPending = 0;
    int          rdCnt = 0;
    logic [31:0] rdAddr;

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        if (ramMem.exists(a)) return ramMem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin : responder
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rdPending) begin
                rdCnt--;
                if (rdCnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ramRead(rdAddr);
                    rdPending  = 0;
                end
            end
            mem_gnt = mem_req && ($urandom_range(0, 99) < gntPct);
            if (mem_gnt && reset) begin
                if (mem_we) ramMem[mem_addr] = mem_wdata;
                else begin rdPending = 1; rdCnt = rdDelay; rdAddr = mem_addr; end
            end
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] qAddr [$];
    logic [31:0] qData [$];
    logic [31:0] writeLog [$];
    int          readReqCount = 0;
    logic [31:0] lastReadAddr = '0;
    logic [31:0] lastReadData = '0;

    initial begin : monitor
        bit          live, readInFlight, expValid, holdPrev, nextValid, isSt, isLd, expStall, hit;
        logic [31:0] w, expData, pAddr, pWdata;
        logic        pWe;
        live = 0; readInFlight = 0; expValid = 0; holdPrev = 0;
        pAddr = '0; pWdata = '0; pWe = 0;
        forever begin
            @(negedge clk); #3;
            if (reset !== 1'b1) begin
                qAddr.delete(); qData.delete();
                readInFlight = 0; expValid = 0; holdPrev = 0; live = 1;
            end else if (live) begin
                isSt = MemWriteM;
                isLd = MemtoRegM && !MemWriteM;
                w    = ALUOutM & 32'hFFFF_FFFC;
                hit = 0; expData = ramRead(w);
                for (int i = qAddr.size() - 1; i >= 0; i--)
                    if (!hit && qAddr[i] == w) begin hit = 1; expData = qData[i]; end

                chk("ReadValidM", {31'b0, ReadValidM}, {31'b0, expValid});
                expStall = isSt ? (qAddr.size() == SB) : (isLd ? !ReadValidM : 1'b0);
                chk("StallM", {31'b0, StallM}, {31'b0, expStall});
                if (ReadValidM) begin
                    chk("valid_without_load", {31'b0, isLd}, 32'd1);
                    chk("ReadDataM", ReadDataM, expData);
                    lastReadData = ReadDataM;
                end
                if (mem_req) chk("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
                if (holdPrev)
                    chk("req_stable", {mem_req, mem_we, mem_addr[29:0]} ^ (mem_wdata ^ pWdata),
                        {1'b1, pWe, pAddr[29:0]});
                if (mem_req && !mem_we) begin
                    chk("read_after_drain", qAddr.size(), 32'd0);
                    chk("read_addr", mem_addr, isLd ? w : 32'hFFFF_FFFF);
                end

                nextValid = (mem_rvalid && readInFlight) ||
                            (FWD && isLd && !ReadValidM && hit);
                if (mem_rvalid) readInFlight = 0;
                if (mem_req && !mem_we && mem_gnt) begin
                    readInFlight = 1; readReqCount++; lastReadAddr = mem_addr;
                end
                if (mem_req && mem_we && mem_gnt) begin
                    if (qAddr.size() == 0) chk("write_unexpected", mem_addr, 32'hFFFF_FFFF);
                    else begin
                        chk("write_addr", mem_addr, qAddr[0]);
                        chk("write_data", mem_wdata, qData[0]);
                        void'(qAddr.pop_front()); void'(qData.pop_front());
                    end
                    writeLog.push_back(mem_addr);
                end
                if (isSt && !expStall) begin qAddr.push_back(w); qData.push_back(WriteDataM); end
                holdPrev = mem_req && !mem_gnt;
                pAddr = mem_addr; pWdata = mem_wdata; pWe = mem_we;
                expValid = nextValid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, output int stalls);
        MemWriteM = wr; MemtoRegM = rd; ALUOutM = a; WriteDataM = d;
        stalls = 0;
        for (int n = 0; n < 300; n++) begin
            #4;
            if (!StallM) begin @(negedge clk); return; end
            stalls++;
            @(negedge clk);
        end
        chk("issue_timeout", 32'd1, 32'd0);
        MemWriteM = 0; MemtoRegM = 0;
    endtask

    task automatic idle(input int n);
        MemWriteM = 0; MemtoRegM = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int st;
        int base;
        reset = 0; MemWriteM = 0; MemtoRegM = 0; ALUOutM = '0; WriteDataM = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_StallM", {31'b0, StallM}, 32'd0);
        chk("rst_ReadValidM", {31'b0, ReadValidM}, 32'd0);
        chk("rst_ReadDataM", ReadDataM, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // load latency: rvalid 2 cycles after gnt, then zero-wait
        gntPct = 100; rdDelay = 2;
        issue(0, 1, 32'h100, 0, st); idle(1);
        chk("load100_data", lastReadData, 32'h0100_FEFF);
        chk("load100_stalls", st, 32'd4);
        rdDelay = 1;
        issue(0, 1, 32'h104, 0, st); idle(1);
        chk("load104_data", lastReadData, 32'h0104_FEFB);
        chk("load104_stalls", st, 32'd3);

        // fill buffer with gnt held low, 5th store must stall
        gntPct = 0; base = writeLog.size();
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), st);
            chk("fill_no_stall", st, 32'd0);
        end
        MemWriteM = 1; ALUOutM = 32'h24; WriteDataM = 32'h1004;
        #4; chk("full_stall_a", {31'b0, StallM}, 32'd1);
        @(negedge clk); #4; chk("full_stall_b", {31'b0, StallM}, 32'd1);
        @(negedge clk);
        gntPct = 100;
        issue(1, 0, 32'h24, 32'h1004, st);
        idle(12);
        if (writeLog.size() >= base + 5) begin
            chk("drain0", writeLog[base], 32'h10);
            chk("drain1", writeLog[base + 1], 32'h14);
            chk("drain2", writeLog[base + 2], 32'h18);
            chk("drain3", writeLog[base + 3], 32'h1C);
            chk("drain4", writeLog[base + 4], 32'h24);
        end else chk("drain_count", writeLog.size() - base, 32'd5);

        // store then load of same word
        base = readReqCount;
        issue(1, 0, 32'h20, 32'hA5A5_A5A5, st);
        issue(0, 1, 32'h20, 0, st); idle(2);
        chk("st_ld_data", lastReadData, 32'hA5A5_A5A5);
        if (FWD) begin
            chk("fwd_stalls", st, 32'd1);
            chk("fwd_no_read", readReqCount, base);
        end else chk("nofwd_read", readReqCount, base + 1);

        // two stores to one word, load sees the younger
        issue(1, 0, 32'h30, 32'h1, st);
        issue(1, 0, 32'h30, 32'h2, st);
        issue(0, 1, 32'h30, 0, st); idle(3);
        chk("youngest_data", lastReadData, 32'h2);

        // unaligned load address
        issue(0, 1, 32'h43, 0, st); idle(1);
        chk("align_addr", lastReadAddr, 32'h40);
        chk("align_data", lastReadData, 32'h0040_FFBF);

        // reset while waiting for read data, stray rvalid must be ignored
        rdDelay = 4;
        MemtoRegM = 1; ALUOutM = 32'h200;
        @(negedge clk); @(negedge clk);
        reset = 0; MemtoRegM = 0;
        @(negedge clk);
        reset = 1;
        #2;
        chk("rst_mid_data", ReadDataM, 32'd0);
        chk("rst_mid_stall", {31'b0, StallM}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            chk("rst_stray_valid", {31'b0, ReadValidM}, 32'd0);
            chk("rst_idle_req", {31'b0, mem_req}, 32'd0);
        end
        @(negedge clk);
        rdDelay = 1;

        // reset discards buffered stores
        gntPct = 0;
        issue(1, 0, 32'h50, 32'h5, st);
        issue(1, 0, 32'h54, 32'h6, st);
        MemWriteM = 0; reset = 0;
        @(negedge clk);
        reset = 1; gntPct = 100; base = writeLog.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("rst_sb_req", {31'b0, mem_req}, 32'd0);
        end
        chk("rst_sb_writes", writeLog.size(), base);
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [31:0] a;
            if (n % 20 == 0) begin
                k = $urandom_range(0, 2);
                gntPct = (k == 0) ? 25 : ((k == 1) ? 60 : 100);
            end
            rdDelay = $urandom_range(1, 3);
            k = $urandom_range(0, 9);
            a = 32'h300 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if (k <= 4)      issue(1, 0, a, $urandom, st);
            else if (k <= 8) issue(0, 1, a, $urandom, st);
            else             issue(1, 1, a, $urandom, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        gntPct = 100;
        idle(20);
        chk("final_drained", qAddr.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
